aec_expr_tx: RTL and testbench

- Transmit side of the serial ASCII expression protocol used by the expression calculator.
- Buffers an infix expression loaded one character at a time, then on `start` streams it one character per clock on `ascii_in` with a leading `ready` pulse, always ending with '='.
- After the stream, waits for the calculator's `valid`/`result` handshake, captures the result and compares it with an expected value.
- Sits between a host or test sequencer and the calculator.

---
 rtl/aec_pkg.sv | 42 ++++
 rtl/aec_tx_buf.sv | 49 ++++
 rtl/aec_expr_tx.sv | 160 ++++++++++++++++
 tb/tb_aec_expr_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aec_pkg.sv
// aec_pkg: shared constants and helpers for the ASCII expression transmitter.
//   - ASCII codes for the operator/bracket/terminator characters
//   - digit and lowercase hex ranges
//   - FSM state encoding for aec_expr_tx
//   - is_legal_char(): load-time character filter
// Optional feature macro: AEC_TX_CHARSET_CHECK_EN
//   defined   -> only '0'-'9', 'a'-'f', '(', ')', '*', '+', '-' are legal
//   undefined -> every byte except '=' is legal
package aec_pkg;

  localparam logic [7:0] CH_LPAR = 8'h28;
  localparam logic [7:0] CH_RPAR = 8'h29;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_ADD  = 8'h2B;
  localparam logic [7:0] CH_SUB  = 8'h2D;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_A    = 8'h61;
  localparam logic [7:0] CH_F    = 8'h66;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SEND     = 3'd1;
  localparam state_t ST_SEND_EQ  = 3'd2;
  localparam state_t ST_WAIT_RES = 3'd3;
  localparam state_t ST_FIN      = 3'd4;

  // '=' is reserved as the frame terminator, so it may never sit in the buffer.
  function automatic logic is_legal_char(input logic [7:0] c);
`ifdef AEC_TX_CHARSET_CHECK_EN
    return ((c >= CH_0) && (c <= CH_9)) ||
           ((c >= CH_A) && (c <= CH_F)) ||
           (c == CH_LPAR) || (c == CH_RPAR) ||
           (c == CH_MUL)  || (c == CH_ADD)  || (c == CH_SUB);
`else
    return (c != CH_EQ);
`endif
  endfunction

endpackage

// File: rtl/aec_tx_buf.sv
// aec_tx_buf: character buffer for the expression transmitter.
// Holds up to MAX_LEN-1 characters; writes append at index len.
// Ports:
//   clk, rst   clock, async active-high reset (empties the buffer)
//   clr        empty the buffer (wins over we)
//   we, wdata  append wdata; silently ignored when full
//   rd_idx     combinational read address
//   rd_data    character at rd_idx
//   len        number of stored characters
//   full       len == MAX_LEN-1
module aec_tx_buf #(
  parameter int MAX_LEN = 16,
  parameter int PTR_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [7:0]       wdata,
  input  logic [PTR_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  output logic [PTR_W-1:0] len,
  output logic             full
);

  logic [7:0] mem [0:(2**PTR_W)-1];

  assign full    = (len == PTR_W'(MAX_LEN - 1));
  assign rd_data = mem[rd_idx];

  // Length tracks the fill level; clearing only resets the length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len <= '0;
    end else if (clr) begin
      len <= '0;
    end else if (we && !full) begin
      len <= len + PTR_W'(1);
    end
  end

  // Storage needs no reset: entries at or beyond len are never read out.
  always_ff @(posedge clk) begin
    if (we && !clr && !full) begin
      mem[len] <= wdata;
    end
  end

endmodule

// File: rtl/aec_expr_tx.sv
// aec_expr_tx: transmit side of the serial ASCII expression protocol.
// Buffers an expression, streams it with a leading ready strobe and a
// trailing '=', then waits for the calculator's valid/result and checks it.
// Optional feature macro: AEC_TX_CHARSET_CHECK_EN (restricts legal load chars).
// Ports:
//   clk, rst                 clock, async active-high reset
//   load_clr, load_we        buffer clear / append (IDLE only)
//   load_char                character to append
//   start, exp_result        begin transmission, expected result
//   ready, ascii_in          frame-start strobe, character stream
//   valid, result            calculator result handshake
//   busy, done               transaction in progress, end-of-transaction pulse
//   pass, timeout, res_q     outcome, held until next accepted start
//   overflow, bad_char       sticky load errors, cleared by load_clr
module aec_expr_tx
  import aec_pkg::*;
#(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int PTR_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_clr,
  input  logic       load_we,
  input  logic [7:0] load_char,
  input  logic       start,
  input  logic [6:0] exp_result,
  output logic       ready,
  output logic [7:0] ascii_in,
  input  logic       valid,
  input  logic [6:0] result,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [6:0] res_q,
  output logic       overflow,
  output logic       bad_char
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t           state;
  logic [PTR_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       exp_q;

  logic             idle;
  logic             buf_clr;
  logic             buf_we;
  logic [7:0]       rd_data;
  logic [PTR_W-1:0] buf_len;
  logic             buf_full;

  assign idle    = (state == ST_IDLE);
  assign buf_clr = idle && load_clr;
  assign buf_we  = idle && load_we && !load_clr && is_legal_char(load_char);

  aec_tx_buf #(
    .MAX_LEN (MAX_LEN),
    .PTR_W   (PTR_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .we      (buf_we),
    .wdata   (load_char),
    .rd_idx  (idx),
    .rd_data (rd_data),
    .len     (buf_len),
    .full    (buf_full)
  );

  // Sticky load errors; a full buffer and an illegal byte are flagged independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      bad_char <= 1'b0;
    end else if (idle) begin
      if (load_clr) begin
        overflow <= 1'b0;
        bad_char <= 1'b0;
      end else if (load_we) begin
        if (buf_full) overflow <= 1'b1;
        if (!is_legal_char(load_char)) bad_char <= 1'b1;
      end
    end
  end

  // Transaction FSM: stream buffer, send '=', then wait for result or timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      exp_q   <= '0;
      pass    <= 1'b0;
      timeout <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && (buf_len != '0)) begin
            exp_q   <= exp_result;
            pass    <= 1'b0;
            timeout <= 1'b0;
            res_q   <= '0;
            idx     <= '0;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (idx == (buf_len - PTR_W'(1))) begin
            state <= ST_SEND_EQ;
          end else begin
            idx <= idx + PTR_W'(1);
          end
        end
        ST_SEND_EQ: begin
          cnt   <= '0;
          state <= ST_WAIT_RES;
        end
        ST_WAIT_RES: begin
          // valid takes priority over the terminal count
          if (valid) begin
            res_q <= result;
            pass  <= (result == exp_q);
            state <= ST_FIN;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout <= 1'b1;
            state   <= ST_FIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready = (state == ST_SEND) && (idx == '0);
  assign busy  = (state == ST_SEND) || (state == ST_SEND_EQ) || (state == ST_WAIT_RES);
  assign done  = (state == ST_FIN);

  always_comb begin
    ascii_in = 8'h00;
    if (state == ST_SEND) begin
      ascii_in = rd_data;
    end else if (state == ST_SEND_EQ) begin
      ascii_in = CH_EQ;
    end
  end

endmodule

// File: tb/tb_aec_expr_tx.sv
// tb_aec_expr_tx: self-checking bench for aec_expr_tx.
// Table-driven transactions, hand-written corner sequences and randomized
// transactions, all checked against a queue-based reference model.
module tb_aec_expr_tx;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int PTR_W       = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_clr = 1'b0;
  logic       load_we = 1'b0;
  logic [7:0] load_char = 8'h00;
  logic       start = 1'b0;
  logic [6:0] exp_result = 7'd0;
  logic       valid = 1'b0;
  logic [6:0] result = 7'd0;
  logic       ready;
  logic [7:0] ascii_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic       timeout;
  logic [6:0] res_q;
  logic       overflow;
  logic       bad_char;

  int total = 0;
  int bad = 0;

  // reference model: buffered characters and sticky flags
  byte unsigned mq[$];
  bit           m_ovf;
  bit           m_bad;

  typedef struct {
    string    expr;
    bit [6:0] e;
    bit [6:0] r;
    int       d;
  } vec_t;

  vec_t tbl[6];

  aec_expr_tx #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .PTR_W       (PTR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_clr   (load_clr),
    .load_we    (load_we),
    .load_char  (load_char),
    .start      (start),
    .exp_result (exp_result),
    .ready      (ready),
    .ascii_in   (ascii_in),
    .valid      (valid),
    .result     (result),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .res_q      (res_q),
    .overflow   (overflow),
    .bad_char   (bad_char)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic bit model_legal(input byte unsigned c);
`ifdef AEC_TX_CHARSET_CHECK_EN
    string ok;
    ok = "0123456789abcdef()*+-";
    for (int i = 0; i < ok.len(); i++) begin
      if (ok[i] == c) return 1'b1;
    end
    return 1'b0;
`else
    return (c != 8'h3D);
`endif
  endfunction

  task automatic clearBuf();
    load_clr = 1'b1;
    step();
    load_clr = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
  endtask

  task automatic loadByte(input byte unsigned c);
    load_we   = 1'b1;
    load_char = c;
    step();
    load_we = 1'b0;
    if (!model_legal(c)) m_bad = 1'b1;
    if (mq.size() == MAX_LEN - 1) m_ovf = 1'b1;
    else if (model_legal(c)) mq.push_back(c);
  endtask

  task automatic loadString(input string s);
    clearBuf();
    for (int i = 0; i < s.len(); i++) loadByte(s[i]);
    checkOutput({s, " flags"}, {30'd0, overflow, bad_char}, {30'd0, m_ovf, m_bad});
  endtask

  // One full transaction; d = cycle (counted from the '=' cycle) on which valid
  // is raised, 0 for never. noise adds ignored valid/load traffic while sending.
  task automatic runTxn(input string name, input bit [6:0] e, input bit [6:0] r,
                        input int d, input bit noise);
    int  n;
    int  done_at;
    int  seen;
    bit  respond;
    n       = mq.size();
    respond = (d >= 1) && (d <= TIMEOUT_CYC);
    done_at = respond ? d + 1 : TIMEOUT_CYC + 1;
    seen    = -1;

    start = 1'b1;
    exp_result = e;
    result = r;
    step();
    start = 1'b0;
    exp_result = 7'($urandom);
    checkOutput({name, " cleared"}, {23'd0, pass, timeout, res_q}, 32'd0);

    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s char%0d", name, k), {22'd0, busy, ready, ascii_in},
                  {22'd0, 1'b1, 1'(k == 0), mq[k]});
      if (noise) begin
        valid     = 1'($urandom_range(0, 1));
        load_we   = 1'($urandom_range(0, 1));
        load_clr  = 1'($urandom_range(0, 3) == 0);
        load_char = "7";
      end
      step();
    end
    checkOutput({name, " eq"}, {22'd0, busy, ready, ascii_in}, {22'd0, 1'b1, 1'b0, 8'h3D});
    if (noise) valid = 1'($urandom_range(0, 1));
    load_we  = 1'b0;
    load_clr = 1'b0;
    step();

    for (int j = 1; j <= TIMEOUT_CYC + 5; j++) begin
      valid = (j == d);
      if (j == 1) checkOutput({name, " wait"}, {23'd0, busy, ascii_in}, {23'd0, 1'b1, 8'h00});
      if (done) begin
        seen = j;
        break;
      end
      step();
    end
    checkOutput({name, " done cycle"}, seen, done_at);
    checkOutput({name, " outcome"}, {23'd0, pass, timeout, res_q},
                respond ? {23'd0, 1'(r == e), 1'b0, r} : {23'd0, 1'b0, 1'b1, 7'd0});
    step();
    valid = 1'b0;
    checkOutput({name, " after"}, {21'd0, done, busy, pass, timeout, res_q},
                respond ? {21'd0, 2'b00, 1'(r == e), 1'b0, r} : {21'd0, 2'b00, 2'b01, 7'd0});
  endtask

  task automatic applyStimulus(input vec_t v);
    loadString(v.expr);
    runTxn(v.expr, v.e, v.r, v.d, 1'b0);
  endtask

  task automatic checkIgnoredStart(input string name);
    start = 1'b1;
    exp_result = 7'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("%s idle%0d", name, i), {29'd0, busy, ready, done}, 32'd0);
      step();
    end
  endtask

  initial begin
    tbl[0] = '{"1+2",     7'd3,  7'd3,  3};
    tbl[1] = '{"(a-3)*2", 7'd14, 7'd13, 1};
    tbl[2] = '{"5",       7'd5,  7'd5,  0};
    tbl[3] = '{"9*9",     7'd81, 7'd81, TIMEOUT_CYC};
    tbl[4] = '{"7-7",     7'd0,  7'd5,  TIMEOUT_CYC + 1};
    tbl[5] = '{"f",       7'd15, 7'd15, 1};

    // reset state
    step();
    step();
    checkOutput("reset outputs",
                {10'd0, ready, ascii_in, busy, done, pass, timeout, res_q, overflow, bad_char}, 32'd0);
    rst = 1'b0;
    step();

    // table-driven transactions
    for (int i = 0; i < 6; i++) applyStimulus(tbl[i]);

    // timeout followed by a resend of the retained buffer
    loadString("5");
    runTxn("to5", 7'd5, 7'd0, 0, 1'b0);
    runTxn("resend5", 7'd5, 7'd5, 2, 1'b0);

    // overflow: 16 writes, 15 stored
    clearBuf();
    for (int i = 0; i < 16; i++) loadByte(8'(8'h30 + (i % 10)));
    checkOutput("ovf flags", {30'd0, overflow, bad_char}, {30'd0, m_ovf, m_bad});
    checkOutput("ovf len", mq.size(), MAX_LEN - 1);
    runTxn("full", 7'd9, 7'd9, 4, 1'b0);

    // clear and write together: clear wins, buffer empty, start ignored
    load_clr  = 1'b1;
    load_we   = 1'b1;
    load_char = "4";
    step();
    load_clr = 1'b0;
    load_we  = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
    checkOutput("clr flags", {30'd0, overflow, bad_char}, 32'd0);
    checkIgnoredStart("empty");

    // illegal characters
    clearBuf();
    loadByte("1");
    loadByte("=");
    loadByte("g");
    loadByte("2");
    checkOutput("bad flags", {30'd0, overflow, bad_char}, {30'd0, 1'b0, 1'b1});
    runTxn("badchar", 7'd12, 7'd12, 5, 1'b0);

    // reset in the middle of SEND
    loadString("1=23");
    start = 1'b1;
    exp_result = 7'd6;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    checkOutput("midreset outputs",
                {10'd0, ready, ascii_in, busy, done, pass, timeout, res_q, overflow, bad_char}, 32'd0);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_bad = 1'b0;
    checkIgnoredStart("postreset");

    // randomized transactions
    for (int t = 0; t < 15; t++) begin
      string pool;
      int    n;
      int    eqpos;
      bit [6:0] r;
      bit [6:0] e;
      pool  = "0123456789+-*()";
      n     = $urandom_range(1, 14);
      eqpos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      clearBuf();
      for (int i = 0; i < n; i++) begin
        if (i == eqpos) loadByte("=");
        loadByte(pool[$urandom_range(0, pool.len() - 1)]);
      end
      checkOutput($sformatf("rnd%0d flags", t), {30'd0, overflow, bad_char}, {30'd0, m_ovf, m_bad});
      r = 7'($urandom);
      e = ($urandom_range(0, 1) == 1) ? r : 7'($urandom);
      runTxn($sformatf("rnd%0d", t), e, r, $urandom_range(1, TIMEOUT_CYC + 8), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
